// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut, a 32x32 register file and the ALU,
// steered cycle by cycle by the control unit's selects and enables.
module mips_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic        ALUSrcA,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  PCSrc,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic        PCWrite,
  input  logic        BEQ,
  input  logic        BNE,
  input  logic        RegWrite,
  input  logic [3:0]  ALU_Ctl,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        Zero,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf_q [32];

  logic [4:0]  rs, rt, rd, wr_addr;
  logic [31:0] rs_data, rt_data, wr_data;
  logic [31:0] sext_imm, src_a, src_b, alu_res;
  logic        pc_we;

  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  // R0 is hardwired to zero regardless of what the storage holds.
  assign rs_data = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_data = (rt == 5'd0) ? '0 : rf_q[rt];
  assign wr_addr = RegDst ? rd : rt;
  assign wr_data = MemtoReg ? mdr_q : aluout_q;

  assign src_a = ALUSrcA ? a_q : pc_q;

  always_comb begin
    src_b = b_q;
    unique case (ALUSrcB)
      2'b00: src_b = b_q;
      2'b01: src_b = 32'd4;
      2'b10: src_b = sext_imm;
      2'b11: src_b = {sext_imm[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (ALU_Ctl)
      ALU_AND: alu_res = src_a & src_b;
      ALU_OR:  alu_res = src_a | src_b;
      ALU_ADD: alu_res = src_a + src_b;
      ALU_SUB: alu_res = src_a - src_b;
      ALU_SLT: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_NOR: alu_res = ~(src_a | src_b);
      default: alu_res = '0;
    endcase
  end

  assign Zero = (alu_res == '0);

  always_comb begin
    pc_d = alu_res;
    unique case (PCSrc)
      2'b00: pc_d = alu_res;
      2'b01: pc_d = aluout_q;
      2'b10: pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      2'b11: pc_d = alu_res;
    endcase
  end

  assign pc_we = PCWrite | (BEQ & Zero) | (BNE & ~Zero);

  // A/B sample the register file before this edge's write lands, so a
  // same-cycle read of the written register sees the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      a_q      <= rs_data;
      b_q      <= rt_data;
      aluout_q <= alu_res;
      mdr_q    <= dmem_rdata;
      if (IRWrite) begin
        ir_q <= imem_rdata;
      end
      if (pc_we) begin
        pc_q <= pc_d;
      end
      if (RegWrite && (wr_addr != 5'd0)) begin
        rf_q[wr_addr] <= wr_data;
      end
    end
  end

  assign Opcode     = ir_q[31:26];
  assign Funct      = ir_q[5:0];
  assign imem_addr  = pc_q;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;
  assign dmem_we    = MemWrite;

endmodule
